// File: rtl/mp3_frame_sequencer_pkg.sv
// rtl/mp3_frame_sequencer_pkg.sv - parse/fetch state types, sync constants and Layer III frame-length table
package mp3_pkg;

   typedef enum logic [2:0] {P_HUNT, P_H1, P_H2, P_H3, P_EMIT, P_STREAM} parse_state_t;
   typedef enum logic [1:0] {F_IDLE, F_REQ, F_RX} fetch_state_t;

   localparam logic [7:0] SYNC_BYTE0 = 8'hFF;
   localparam logic [7:0] SYNC_MASK  = 8'hFE;
   localparam logic [7:0] SYNC_BYTE1 = 8'hFA;

   // floor(144000 * kbps / Hz); rows 44.1 kHz, 48 kHz, 32 kHz; column = bitrate index
   localparam logic [10:0] FRAME_LEN [3][15] = '{
      '{11'd0, 11'd104, 11'd130, 11'd156, 11'd182, 11'd208, 11'd261, 11'd313,
        11'd365, 11'd417, 11'd522, 11'd626, 11'd731, 11'd835, 11'd1044},
      '{11'd0, 11'd96, 11'd120, 11'd144, 11'd168, 11'd192, 11'd240, 11'd288,
        11'd336, 11'd384, 11'd480, 11'd576, 11'd672, 11'd768, 11'd960},
      '{11'd0, 11'd144, 11'd180, 11'd216, 11'd252, 11'd288, 11'd360, 11'd432,
        11'd504, 11'd576, 11'd720, 11'd864, 11'd1008, 11'd1152, 11'd1440}
   };

   function automatic logic hdr_valid(input logic [7:0] b);
      return (b[7:4] != 4'd0) && (b[7:4] != 4'd15) && (b[3:2] != 2'd3);
   endfunction

   function automatic logic [10:0] frame_len(input logic [7:0] b);
      return FRAME_LEN[b[3:2]][b[7:4]] + {10'd0, b[1]};
   endfunction

endpackage

// File: rtl/mp3_frame_sequencer_fetcher.sv
// rtl/mp3_frame_sequencer_fetcher.sv - sd_sector_fetcher: issues sector reads and counts the returned bytes
module sd_sector_fetcher
   import mp3_pkg::*;
#(
   parameter int SECTOR_BYTES = 512,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              sd_ready,
   input  logic              sd_byte_available,
   output logic              sd_rd,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              byte_stb,
   output logic              sector_done
);

   localparam int CNT_W = $clog2(SECTOR_BYTES);

   fetch_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              sd_rd_q, sd_rd_d;
   logic              last_byte;

   assign byte_stb    = sd_byte_available && (state_q == F_RX);
   assign last_byte   = (cnt_q == CNT_W'(SECTOR_BYTES - 1));
   assign sector_done = byte_stb && last_byte;
   assign sd_rd       = sd_rd_q;
   assign sd_addr     = addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= F_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         sd_rd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sd_rd_q <= sd_rd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         F_IDLE:  if (start) state_d = F_REQ;
         F_REQ:   if (sd_ready) state_d = F_RX;
         F_RX:    if (sector_done) state_d = F_REQ;
         default: state_d = F_IDLE;
      endcase
   end

   // start is only honoured from IDLE; a busy engine ignores it
   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      sd_rd_d = 1'b0;
      if ((state_q == F_IDLE) && start) addr_d = base_addr;
      if ((state_q == F_REQ) && sd_ready) sd_rd_d = 1'b1;
      if (byte_stb) cnt_d = last_byte ? '0 : cnt_q + 1'b1;
      if (sector_done) addr_d = addr_q + ADDR_W'(SECTOR_BYTES);
   end

endmodule

// File: rtl/mp3_frame_sequencer.sv
// rtl/mp3_frame_sequencer.sv - sector reads, MPEG-1 Layer III sync hunt and per-frame byte forwarding
// Optional FRAME_COUNT_EN adds a 16-bit frame_count output.
module mp3_frame_sequencer
   import mp3_pkg::*;
#(
   parameter int SECTOR_BYTES = 512,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              sd_ready,
   output logic              sd_rd,
   output logic [ADDR_W-1:0] sd_addr,
   input  logic              sd_byte_available,
   input  logic [7:0]        sd_din,
   output logic [7:0]        d_out,
   output logic              d_ov,
   output logic              frame_start,
   output logic [10:0]       frame_size,
   output logic              locked
`ifdef FRAME_COUNT_EN
   ,
   output logic [15:0]       frame_count
`endif
);

   parse_state_t pstate_q, pstate_d;
   logic         byte_stb, sector_done;
   logic [7:0]   hdr1_q, hdr1_d, hdr2_q, hdr2_d, hdr3_q, hdr3_d, hdr_byte;
   logic [1:0]   emit_idx_q, emit_idx_d;
   logic [10:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]   d_out_q, d_out_d;
   logic         d_ov_q, d_ov_d, frame_start_q, frame_start_d, locked_q, locked_d;
   logic [10:0]  frame_size_q, frame_size_d;

   sd_sector_fetcher #(.SECTOR_BYTES(SECTOR_BYTES), .ADDR_W(ADDR_W)) u_fetch (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_addr         (base_addr),
      .sd_ready          (sd_ready),
      .sd_byte_available (sd_byte_available),
      .sd_rd             (sd_rd),
      .sd_addr           (sd_addr),
      .byte_stb          (byte_stb),
      .sector_done       (sector_done)
   );

   assign d_out       = d_out_q;
   assign d_ov        = d_ov_q;
   assign frame_start = frame_start_q;
   assign frame_size  = frame_size_q;
   assign locked      = locked_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pstate_q <= P_HUNT;
      else     pstate_q <= pstate_d;
   end

   // frame boundaries are judged on the byte stream alone, so sector_done never disturbs parsing
   always_comb begin
      pstate_d = pstate_q;
      case (pstate_q)
         P_HUNT: if (byte_stb && (sd_din == SYNC_BYTE0)) pstate_d = P_H1;
         P_H1: if (byte_stb) begin
            if ((sd_din & SYNC_MASK) == SYNC_BYTE1) pstate_d = P_H2;
            else if (sd_din != SYNC_BYTE0)          pstate_d = P_HUNT;
         end
         P_H2:     if (byte_stb) pstate_d = hdr_valid(sd_din) ? P_H3 : P_HUNT;
         P_H3:     if (byte_stb) pstate_d = P_EMIT;
         P_EMIT:   if (emit_idx_q == 2'd3) pstate_d = P_STREAM;
         P_STREAM: if (byte_stb && (byte_cnt_q == frame_size_q))
                      pstate_d = (sd_din == SYNC_BYTE0) ? P_H1 : P_HUNT;
         default:  pstate_d = P_HUNT;
      endcase
   end

   always_comb begin
      case (emit_idx_q)
         2'd0:    hdr_byte = SYNC_BYTE0;
         2'd1:    hdr_byte = hdr1_q;
         2'd2:    hdr_byte = hdr2_q;
         default: hdr_byte = hdr3_q;
      endcase
   end

   always_comb begin
      hdr1_d        = hdr1_q;
      hdr2_d        = hdr2_q;
      hdr3_d        = hdr3_q;
      emit_idx_d    = emit_idx_q;
      byte_cnt_d    = byte_cnt_q;
      d_out_d       = d_out_q;
      d_ov_d        = 1'b0;
      frame_start_d = 1'b0;
      frame_size_d  = frame_size_q;
      locked_d      = locked_q;
      case (pstate_q)
         P_H1: if (byte_stb) begin
            if ((sd_din & SYNC_MASK) == SYNC_BYTE1) hdr1_d   = sd_din;
            else if (sd_din != SYNC_BYTE0)          locked_d = 1'b0;
         end
         P_H2: if (byte_stb) begin
            if (hdr_valid(sd_din)) hdr2_d   = sd_din;
            else                   locked_d = 1'b0;
         end
         P_H3: if (byte_stb) begin
            hdr3_d     = sd_din;
            emit_idx_d = 2'd0;
         end
         P_EMIT: begin
            d_out_d    = hdr_byte;
            d_ov_d     = 1'b1;
            locked_d   = 1'b1;
            emit_idx_d = emit_idx_q + 2'd1;
            byte_cnt_d = 11'd4;
            if (emit_idx_q == 2'd0) begin
               frame_start_d = 1'b1;
               frame_size_d  = frame_len(hdr2_q);
            end
         end
         P_STREAM: if (byte_stb) begin
            if (byte_cnt_q != frame_size_q) begin
               d_out_d    = sd_din;
               d_ov_d     = 1'b1;
               byte_cnt_d = byte_cnt_q + 11'd1;
            end else if (sd_din != SYNC_BYTE0) begin
               locked_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr1_q        <= '0;
         hdr2_q        <= '0;
         hdr3_q        <= '0;
         emit_idx_q    <= '0;
         byte_cnt_q    <= '0;
         d_out_q       <= '0;
         d_ov_q        <= 1'b0;
         frame_start_q <= 1'b0;
         frame_size_q  <= '0;
         locked_q      <= 1'b0;
      end else begin
         hdr1_q        <= hdr1_d;
         hdr2_q        <= hdr2_d;
         hdr3_q        <= hdr3_d;
         emit_idx_q    <= emit_idx_d;
         byte_cnt_q    <= byte_cnt_d;
         d_out_q       <= d_out_d;
         d_ov_q        <= d_ov_d;
         frame_start_q <= frame_start_d;
         frame_size_q  <= frame_size_d;
         locked_q      <= locked_d;
      end
   end

`ifdef FRAME_COUNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      if (start)              frame_count_d = '0;
      else if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_count_q <= '0;
      else     frame_count_q <= frame_count_d;
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_mp3_frame_sequencer.sv
// tb/tb_mp3_frame_sequencer.sv - self-checking bench: header table, directed sequences, random streams vs reference
module tb_mp3_frame_sequencer;

   localparam int SEC = 512;
   localparam int MEM_BYTES = 8 * SEC;

   typedef struct packed {
      logic [7:0]  b;
      logic        fs;
      logic [10:0] size;
      logic        lk;
   } obs_t;

   typedef struct {
      logic [7:0] b2;
      int         size;
      int         n_ov;
      bit         lk_end;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic        sd_ready, sd_rd, sd_byte_available, d_ov, frame_start, locked;
   logic [31:0] sd_addr;
   logic [7:0]  sd_din, d_out;
   logic [10:0] frame_size;

   logic [7:0]  mem [MEM_BYTES];
   int          nsec = 0;
   obs_t        got[$];
   obs_t        exp_q[$];
   logic [31:0] addr_log[$];
   int          falls, stray, exp_falls;
   logic        lk_prev;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mp3_frame_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_addr         (base_addr),
      .sd_ready          (sd_ready),
      .sd_rd             (sd_rd),
      .sd_addr           (sd_addr),
      .sd_byte_available (sd_byte_available),
      .sd_din            (sd_din),
      .d_out             (d_out),
      .d_ov              (d_ov),
      .frame_start       (frame_start),
      .frame_size        (frame_size),
      .locked            (locked)
   );

   // SD reader: serves sector k of mem for the k-th read, one byte every 6 cycles
   initial begin : reader
      int sec;
      sd_ready = 1'b1;
      sd_byte_available = 1'b0;
      sd_din = '0;
      sec = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sec = 0;
            sd_ready = 1'b1;
            sd_byte_available = 1'b0;
            addr_log.delete();
         end else if (sd_rd) begin
            addr_log.push_back(sd_addr);
            sd_ready = 1'b0;
            if (sec < nsec) begin
               for (int k = 0; k < SEC; k++) begin
                  repeat (5) @(negedge clk);
                  if (rst) break;
                  sd_din = mem[sec*SEC + k];
                  sd_byte_available = 1'b1;
                  @(negedge clk);
                  sd_byte_available = 1'b0;
               end
               sec++;
               if (!rst && sec < nsec) sd_ready = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         got.delete();
         falls = 0;
         stray = 0;
         lk_prev = 1'b0;
      end else begin
         if (d_ov) got.push_back('{b: d_out, fs: frame_start, size: frame_size, lk: locked});
         if (frame_start && !d_ov) stray++;
         if (lk_prev && !locked) falls++;
         lk_prev = locked;
      end
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic bit hdr_ok(input logic [7:0] b);
      return (b[7:4] != 4'd0) && (b[7:4] != 4'd15) && (b[3:2] != 2'd3);
   endfunction

   function automatic int ref_len(input logic [7:0] b);
      int kbps [15] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320};
      int hz [3] = '{44100, 48000, 32000};
      return (144000 * kbps[b[7:4]]) / hz[b[3:2]] + int'(b[1]);
   endfunction

   // Reference: walk the byte stream by the framing rules and list every byte that should be forwarded
   task automatic build_expect(input int n);
      int i, len;
      bit h1, lk;
      logic [7:0] b1, b2, b3;
      exp_q.delete();
      exp_falls = 0;
      i = 0; h1 = 0; lk = 0;
      while (i < n) begin
         if (!h1) begin
            h1 = (mem[i] == 8'hFF);
            i++;
         end else if (mem[i] == 8'hFF) begin
            i++;
         end else if ((mem[i] & 8'hFE) != 8'hFA) begin
            h1 = 0; i++;
            if (lk) exp_falls++;
            lk = 0;
         end else begin
            b1 = mem[i]; h1 = 0; i++;
            if (i >= n) break;
            b2 = mem[i]; i++;
            if (!hdr_ok(b2)) begin
               if (lk) exp_falls++;
               lk = 0;
               continue;
            end
            if (i >= n) break;
            b3 = mem[i]; i++;
            len = ref_len(b2);
            lk = 1;
            exp_q.push_back('{b: 8'hFF, fs: 1'b1, size: 11'(len), lk: 1'b1});
            exp_q.push_back('{b: b1, fs: 1'b0, size: 11'(len), lk: 1'b1});
            exp_q.push_back('{b: b2, fs: 1'b0, size: 11'(len), lk: 1'b1});
            exp_q.push_back('{b: b3, fs: 1'b0, size: 11'(len), lk: 1'b1});
            for (int k = 4; k < len && i < n; k++) begin
               exp_q.push_back('{b: mem[i], fs: 1'b0, size: 11'(len), lk: 1'b1});
               i++;
            end
            if (i >= n) break;
            if (mem[i] == 8'hFF) h1 = 1;
            else begin
               exp_falls++;
               lk = 0;
            end
            i++;
         end
      end
   endtask

   task automatic clear_mem();
      for (int k = 0; k < MEM_BYTES; k++) mem[k] = 8'h00;
   endtask

   task automatic put_frame(input int pos, input logic [7:0] b2, output int next);
      int len;
      len = ref_len(b2);
      for (int k = 0; k < len && pos + k < MEM_BYTES; k++)
         mem[pos + k] = (k == 0) ? 8'hFF : (k == 1) ? 8'hFB : (k == 2) ? b2 : (k == 3) ? 8'h64 : 8'h55;
      next = pos + len;
   endtask

   task automatic begin_run(input logic [31:0] base, input int n);
      nsec = n;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      base_addr = base;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base_addr = '0;
   endtask

   task automatic run(input logic [31:0] base, input int n, input string name);
      int bad;
      begin_run(base, n);
      repeat (n * (SEC * 6 + 40) + 100) @(negedge clk);
      chk({name, " sector_reads"}, addr_log.size(), n);
      for (int k = 0; k < n && k < addr_log.size(); k++)
         chk({name, " sd_addr"}, addr_log[k], base + 32'(k * SEC));
      build_expect(n * SEC);
      chk({name, " d_ov_count"}, got.size(), exp_q.size());
      bad = -1;
      for (int k = 0; k < got.size() && k < exp_q.size(); k++)
         if (bad < 0 && got[k] !== exp_q[k]) bad = k;
      if (bad >= 0)
         $display("  first difference at byte %0d: got %h expected %h", bad, got[bad], exp_q[bad]);
      chk({name, " first_bad_byte"}, bad, -1);
      chk({name, " locked_falls"}, falls, exp_falls);
      chk({name, " stray_frame_start"}, stray, 0);
   endtask

   initial begin : main
      vec_t vecs[$];
      int pos, len;
      logic [7:0] b2;

      vecs.push_back('{b2: 8'h90, size: 417,  n_ov: 417, lk_end: 1'b0});
      vecs.push_back('{b2: 8'h92, size: 418,  n_ov: 418, lk_end: 1'b0});
      vecs.push_back('{b2: 8'hE4, size: 960,  n_ov: 512, lk_end: 1'b1});
      vecs.push_back('{b2: 8'hEA, size: 1441, n_ov: 512, lk_end: 1'b1});
      vecs.push_back('{b2: 8'h10, size: 104,  n_ov: 104, lk_end: 1'b0});
      vecs.push_back('{b2: 8'h18, size: 144,  n_ov: 144, lk_end: 1'b0});
      vecs.push_back('{b2: 8'hF0, size: 0,    n_ov: 0,   lk_end: 1'b0});
      vecs.push_back('{b2: 8'h0C, size: 0,    n_ov: 0,   lk_end: 1'b0});
      vecs.push_back('{b2: 8'h9C, size: 0,    n_ov: 0,   lk_end: 1'b0});

      repeat (3) @(negedge clk);
      chk("reset sd_rd", sd_rd, 0);
      chk("reset sd_addr", sd_addr, 0);
      chk("reset d_out", d_out, 0);
      chk("reset d_ov", d_ov, 0);
      chk("reset frame_start", frame_start, 0);
      chk("reset frame_size", frame_size, 0);
      chk("reset locked", locked, 0);

      foreach (vecs[v]) begin
         clear_mem();
         mem[0] = 8'hFF; mem[1] = 8'hFB; mem[2] = vecs[v].b2; mem[3] = 8'h64;
         run(32'h1000 * (v + 1), 1, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d n_ov", v), got.size(), vecs[v].n_ov);
         chk($sformatf("vec%0d frame_size", v), frame_size, vecs[v].size);
         chk($sformatf("vec%0d locked_end", v), locked, vecs[v].lk_end);
         if (got.size() > 0) chk($sformatf("vec%0d first_fs", v), got[0].fs, 1);
      end

      // back-to-back frames across a sector boundary
      clear_mem();
      put_frame(0, 8'h90, pos);
      put_frame(pos, 8'h90, pos);
      put_frame(pos, 8'h92, pos);
      run(32'h400, 2, "seqA");
      chk("seqA addr0", addr_log.size() > 0 ? addr_log[0] : 0, 32'h400);
      chk("seqA addr1", addr_log.size() > 1 ? addr_log[1] : 0, 32'h600);
      chk("seqA hdr0", got.size() > 0 ? {got[0].b, got[0].fs, got[0].size} : 0, {8'hFF, 1'b1, 11'd417});
      chk("seqA second_fs", got.size() > 417 ? got[417].fs : 0, 1);
      chk("seqA third_size", got.size() > 834 ? got[834].size : 0, 418);

      // garbage before sync, then a non-header after each frame
      clear_mem();
      mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h12; mem[3] = 8'hFF;
      put_frame(4, 8'h90, pos);
      put_frame(600, 8'h92, pos);
      run(32'h2000, 2, "seqB");
      chk("seqB n_ov", got.size(), 417 + 418);
      chk("seqB first_byte", got.size() > 0 ? got[0].b : 0, 8'hFF);
      chk("seqB falls", falls, 2);
      chk("seqB refire", got.size() > 417 ? got[417].fs : 0, 1);
      chk("seqB locked_end", locked, 0);

      // header straddling sectors
      clear_mem();
      put_frame(510, 8'h90, pos);
      run(32'h8000, 2, "seqD");
      chk("seqD n_ov", got.size(), 417);
      chk("seqD hdr2", got.size() > 3 ? {got[2].b, got[3].b} : 0, {8'h90, 8'h64});

      // randomized stream: frames of random valid headers interleaved with garbage
      clear_mem();
      pos = 0;
      while (pos < 3 * SEC) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 12)) begin
               if (pos < MEM_BYTES) mem[pos] = 8'($urandom);
               pos++;
            end
         end else begin
            b2 = {4'($urandom_range(1, 14)), 2'($urandom_range(0, 2)), 2'($urandom)};
            len = ref_len(b2);
            for (int k = 0; k < len; k++) begin
               if (pos < MEM_BYTES)
                  mem[pos] = (k == 0) ? 8'hFF : (k == 1) ? {7'h7D, 1'($urandom)} :
                             (k == 2) ? b2 : 8'($urandom);
               pos++;
            end
         end
      end
      run({$urandom, 9'd0}, 3, "rand");

      // reset mid-frame
      clear_mem();
      put_frame(0, 8'h90, pos);
      begin_run(32'h800, 1);
      repeat (700) @(negedge clk);
      chk("rstmid locked_before", locked, 1);
      chk("rstmid size_before", frame_size, 417);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid sd_addr", sd_addr, 0);
      chk("rstmid d_out", d_out, 0);
      chk("rstmid frame_size", frame_size, 0);
      chk("rstmid locked", locked, 0);
      chk("rstmid d_ov", d_ov, 0);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("rstmid no_reads", addr_log.size(), 0);
      chk("rstmid no_output", got.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
